ex: RTL

Execute stage of the 5-stage MIPS pipeline. It sits between the ID/EX register and the EX/MEM register, and drives the `ex_wd`/`ex_wreg`/`ex_wdata` inputs of EX/MEM.
- Single-cycle ALU ops (logic, shift, add/sub, compare, HI/LO moves) are resolved combinationally.
- DIV/DIVU run on an internal 32-iteration restoring divider. `stallreq` freezes the upstream pipeline until the quotient and remainder are ready.

---
 rtl/ex_if.sv | 29 ++
 rtl/ex.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ex_if.sv
// Signal bundle between the ID/EX register, the execute stage and EX/MEM.
// Master drives operands and control; slave is the execute stage.
interface ex_if;
   logic [7:0]  aluop_i;
   logic [31:0] reg1_i;
   logic [31:0] reg2_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] hi_i;
   logic [31:0] lo_i;
   logic        flush;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        whilo_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        stallreq;

   modport master (
      output aluop_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i, flush,
      input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq
   );

   modport slave (
      input  aluop_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i, flush,
      output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq
   );
endinterface

// File: rtl/ex.sv
// MIPS execute stage: combinational ALU plus a 32-iteration restoring divider
// that stalls the upstream pipeline while a DIV/DIVU is in flight.
module ex (
   input  logic clk,
   input  logic rst,
   ex_if.slave  bus
);
   localparam logic [7:0] OP_AND  = 8'h24;
   localparam logic [7:0] OP_OR   = 8'h25;
   localparam logic [7:0] OP_XOR  = 8'h26;
   localparam logic [7:0] OP_NOR  = 8'h27;
   localparam logic [7:0] OP_SLL  = 8'h7C;
   localparam logic [7:0] OP_SRL  = 8'h02;
   localparam logic [7:0] OP_SRA  = 8'h03;
   localparam logic [7:0] OP_ADDU = 8'h21;
   localparam logic [7:0] OP_SUBU = 8'h23;
   localparam logic [7:0] OP_SLT  = 8'h2A;
   localparam logic [7:0] OP_SLTU = 8'h2B;
   localparam logic [7:0] OP_MFHI = 8'h10;
   localparam logic [7:0] OP_MTHI = 8'h11;
   localparam logic [7:0] OP_MFLO = 8'h12;
   localparam logic [7:0] OP_MTLO = 8'h13;
   localparam logic [7:0] OP_DIV  = 8'h1A;
   localparam logic [7:0] OP_DIVU = 8'h1B;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] dvd_q, dvd_d;       // dividend shifts out, quotient shifts in
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] res_hi_q, res_hi_d;
   logic [31:0] res_lo_q, res_lo_d;
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;

   logic        is_div, a_neg, b_neg, qbit;
   logic [31:0] a_abs, b_abs, rem_nx, quo_nx;
   logic [32:0] part;
   logic [33:0] diff;
   logic [4:0]  shamt;

   assign is_div = (bus.aluop_i == OP_DIV) || (bus.aluop_i == OP_DIVU);
   assign a_neg  = (bus.aluop_i == OP_DIV) && bus.reg1_i[31];
   assign b_neg  = (bus.aluop_i == OP_DIV) && bus.reg2_i[31];
   assign a_abs  = a_neg ? -bus.reg1_i : bus.reg1_i;
   assign b_abs  = b_neg ? -bus.reg2_i : bus.reg2_i;

   // One restoring step: try subtracting the divisor from the widened partial
   // remainder; a clear sign bit means the subtraction fits.
   assign part   = {rem_q, dvd_q[31]};
   assign diff   = {1'b0, part} - {2'b00, dvs_q};
   assign qbit   = ~diff[33];
   assign rem_nx = qbit ? diff[31:0] : part[31:0];
   assign quo_nx = {dvd_q[30:0], qbit};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      res_hi_d  = res_hi_q;
      res_lo_d  = res_lo_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      case (state_q)
         IDLE: begin
            if (is_div) begin
               dvd_d     = a_abs;
               dvs_d     = b_abs;
               rem_d     = 32'd0;
               cnt_d     = 6'd0;
               neg_quo_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               if (bus.reg2_i == 32'd0) begin
                  res_hi_d = 32'd0;
                  res_lo_d = 32'd0;
                  state_d  = DONE;
               end else begin
                  state_d  = BUSY;
               end
            end
         end
         BUSY: begin
            dvd_d = quo_nx;
            rem_d = rem_nx;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               res_lo_d = neg_quo_q ? -quo_nx : quo_nx;
               res_hi_d = neg_rem_q ? -rem_nx : rem_nx;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // flush wins over both progress and a new start
      if (bus.flush) state_d = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 6'd0;
         dvd_q     <= 32'd0;
         dvs_q     <= 32'd0;
         rem_q     <= 32'd0;
         res_hi_q  <= 32'd0;
         res_lo_q  <= 32'd0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         res_hi_q  <= res_hi_d;
         res_lo_q  <= res_lo_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   logic [4:0]  wd;
   logic        wreg, whilo, stall;
   logic [31:0] wdata, hi, lo;

   assign shamt = bus.reg1_i[4:0];

   always_comb begin
      wd    = bus.wd_i;
      wreg  = bus.wreg_i;
      wdata = 32'd0;
      whilo = 1'b0;
      hi    = 32'd0;
      lo    = 32'd0;
      stall = is_div && (state_q != DONE);
      case (bus.aluop_i)
         OP_AND:  wdata = bus.reg1_i & bus.reg2_i;
         OP_OR:   wdata = bus.reg1_i | bus.reg2_i;
         OP_XOR:  wdata = bus.reg1_i ^ bus.reg2_i;
         OP_NOR:  wdata = ~(bus.reg1_i | bus.reg2_i);
         OP_SLL:  wdata = bus.reg2_i << shamt;
         OP_SRL:  wdata = bus.reg2_i >> shamt;
         OP_SRA:  wdata = $signed(bus.reg2_i) >>> shamt;
         OP_ADDU: wdata = bus.reg1_i + bus.reg2_i;
         OP_SUBU: wdata = bus.reg1_i - bus.reg2_i;
         OP_SLT:  wdata = {31'd0, $signed(bus.reg1_i) < $signed(bus.reg2_i)};
         OP_SLTU: wdata = {31'd0, bus.reg1_i < bus.reg2_i};
         OP_MFHI: wdata = bus.hi_i;
         OP_MFLO: wdata = bus.lo_i;
         OP_MTHI: begin whilo = 1'b1; hi = bus.reg1_i; lo = bus.lo_i; end
         OP_MTLO: begin whilo = 1'b1; hi = bus.hi_i; lo = bus.reg1_i; end
         default: wdata = 32'd0;
      endcase
      if (state_q == DONE) begin
         whilo = 1'b1;
         hi    = res_hi_q;
         lo    = res_lo_q;
      end
      if (rst) begin
         wd    = 5'd0;
         wreg  = 1'b0;
         wdata = 32'd0;
         whilo = 1'b0;
         hi    = 32'd0;
         lo    = 32'd0;
         stall = 1'b0;
      end
   end

   assign bus.wd_o     = wd;
   assign bus.wreg_o   = wreg;
   assign bus.wdata_o  = wdata;
   assign bus.whilo_o  = whilo;
   assign bus.hi_o     = hi;
   assign bus.lo_o     = lo;
   assign bus.stallreq = stall;
endmodule
